freqdiv_ctrl: RTL and testbench
===============================

# freqdiv_ctrl

Run-time controller for the programmable clock-enable divider path. It accepts divide-ratio updates over a valid/ready handshake and starts and stops division on command. Ratio changes and stops take effect only at period boundaries, so `clk_out` never has a truncated high or low phase. It sits between the system configuration logic and downstream logic that consumes a divided strobe (`tick`) or a divided square wave (`clk_out`).

## Interface
- `CNT_W`, 16, width of the divide ratio and the phase counter
- `DEF_DIV`, 50, divide ratio loaded at reset; must be ≥2

- `clk`  in  1  system clock
- `rst`  in  1  reset, asynchronous, active-high
- `cfg_valid`  in  1  new divide ratio offered on `cfg_div`
- `cfg_div`  in  CNT_W  requested divide ratio
- `cfg_ready`  out  1  controller can accept a ratio this cycle
- `start`  in  1  one-cycle request to begin or resume division
- `stop`  in  1  one-cycle request to stop at the end of the current period
- `busy`  out  1  state is RUN or STOPPING
- `tick`  out  1  one-cycle strobe in the last cycle of every period
- `clk_out`  out  1  divided square wave
- `div_active`  out  CNT_W  ratio currently in effect

## Operation
- States:
  - IDLE: counter held at 0, `clk_out`=0, `tick`=0.
  - RUN: division is active.
  - STOPPING: division continues until the period ends.
- Transitions:
  - IDLE + `start` → RUN; `cnt`=0 in the first RUN cycle.
  - RUN + `stop` → STOPPING.
  - STOPPING + `start` (without `stop`) → RUN; the stop is cancelled and the phase continues uninterrupted.
  - STOPPING, in the cycle where `tick`=1 → IDLE.
  - `start` and `stop` together: `stop` wins. In IDLE this means no action.
- Phase counter `cnt` counts 0..`div_active`−1 and wraps to 0.
- While in RUN or STOPPING:
  - `tick`=1 exactly when `cnt`==`div_active`−1.
  - `clk_out`=1 exactly when `cnt` < (`div_active`>>1).
  - For an odd ratio, high phase = floor(d/2) cycles and low phase = ceil(d/2) cycles.
- `tick` and `clk_out` are flops computed from next-state `cnt`, so they are glitch-free and aligned with `cnt`.
- Ratio clamp: a `cfg_div` value of 0 or 1 is stored as 2. Any value ≥2 is used as given.
- Configuration handshake:
  - A ratio transfers on any edge where `cfg_valid` && `cfg_ready`.
  - In IDLE, `div_active` updates on that edge and `cfg_ready` stays 1.
  - In RUN or STOPPING, the value is held in a one-deep shadow register and `cfg_ready` drops to 0.
  - The shadow loads into `div_active` on the edge that ends a `tick` cycle, so the next period uses the new ratio and `cfg_ready` returns to 1.
  - Transfer and boundary on the same edge while the shadow is empty: the new value goes to the shadow and applies at the following boundary.
- A pending shadow value when the block enters IDLE is applied on the same edge as the STOPPING→IDLE transition.
- `cfg_valid` while `cfg_ready`=0 has no effect; the requester must hold the value.

## Timing
- Reset values:
  - state IDLE, `cnt`=0
  - `div_active`=`DEF_DIV`, shadow empty
  - `cfg_ready`=1, `busy`=0, `tick`=0, `clk_out`=0
- `start` sampled on edge N: `busy`=1 and `clk_out`=1 from cycle N+1, and the first `tick` in cycle N+`div_active`.
- Stop latency: `busy` falls on the edge after the first `tick` at or after `stop`. The period in progress always completes.
- Config latency:
  - IDLE: 1 cycle.
  - RUN: at most 1 period plus 1 cycle.
- Asserting `rst` mid-operation: all outputs go to their reset values immediately. Shadow contents and the pending stop are discarded.
- The counter compares against `div_active`−1 only, so no overflow is possible. The maximum ratio is 2^CNT_W−1.

## Test plan
- Reset then `start` with `DEF_DIV`=50 → `clk_out` high 25 / low 25 cycles, `tick` every 50 cycles, first `tick` 50 cycles after `start`.
- In IDLE, write `cfg_div`=5, then `start` → `div_active`=5 after 1 cycle; `clk_out` pattern 1,1,0,0,0 repeating; `tick` on the 5th cycle of each period.
- While running at ratio 10, write `cfg_div`=4 at `cnt`=3 → `cfg_ready`=0 until the current 10-cycle period ends; the next period is 4 cycles; a second `cfg_valid` during the wait is not accepted.
- Running at ratio 8, pulse `stop` at `cnt`=2 → `tick` at `cnt`=7, then `busy`=0 and `clk_out`=0 the next cycle. Repeat with `start` at `cnt`=5 → no stop, continuous phase.
- Write `cfg_div`=0, then `cfg_div`=1 → `div_active`=2; `clk_out` toggles every cycle; `tick` on every other cycle.
- Assert `rst` for 1 cycle mid-period with a shadow value pending → all outputs at reset values, `div_active`=50, pending value lost, `cfg_ready`=1.

Source files
------------

// File: rtl/freqdiv_ctrl.sv
// freqdiv_ctrl: run-time controller for a programmable clock-enable divider.
// Accepts divide-ratio updates over valid/ready and starts or stops division
// on command. Ratio changes and stops only take effect at period boundaries,
// so clk_out never has a truncated high or low phase.
module freqdiv_ctrl #(
  parameter int CNT_W   = 16,
  parameter int DEF_DIV = 50
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_valid,
  input  logic [CNT_W-1:0] cfg_div,
  output logic             cfg_ready,
  input  logic             start,
  input  logic             stop,
  output logic             busy,
  output logic             tick,
  output logic             clk_out,
  output logic [CNT_W-1:0] div_active
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    STOPPING = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] div_q, div_d;
  logic [CNT_W-1:0] shadow_q, shadow_d;
  logic             shadow_vld_q, shadow_vld_d;
  logic             tick_q, tick_d;
  logic             clk_out_q, clk_out_d;

  logic [CNT_W-1:0] cfg_clamped;
  logic             xfer;
  logic             at_end;
  logic             busy_d;

  // Ratios below 2 cannot form a period with both phases; store them as 2.
  always_comb begin
    cfg_clamped = (cfg_div < CNT_W'(2)) ? CNT_W'(2) : cfg_div;
  end

  // Next-state logic: FSM, phase counter, ratio/shadow handling, and the
  // registered outputs derived from the next counter value.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves one
    // unassigned, which would otherwise infer a latch.
    state_d      = state_q;
    cnt_d        = cnt_q;
    div_d        = div_q;
    shadow_d     = shadow_q;
    shadow_vld_d = shadow_vld_q;

    // A transfer happens whenever the shadow is free; in IDLE it is always free.
    xfer   = cfg_valid && !shadow_vld_q;
    at_end = (state_q != IDLE) && (cnt_q == div_q - CNT_W'(1));

    unique case (state_q)
      IDLE: begin
        if (start && !stop) state_d = RUN;
      end
      RUN: begin
        // A stop seen in the last cycle of a period ends division on this edge.
        if (stop) state_d = at_end ? IDLE : STOPPING;
      end
      STOPPING: begin
        if (start && !stop) state_d = RUN;
        else if (at_end)    state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Counter restarts at 0 on every period boundary and whenever not running.
    if (state_q == IDLE || state_d == IDLE || at_end) cnt_d = '0;
    else                                              cnt_d = cnt_q + CNT_W'(1);

    // A pending ratio applies at the boundary, including the one that ends a stop.
    if (at_end && shadow_vld_q) begin
      div_d        = shadow_q;
      shadow_vld_d = 1'b0;
    end

    // Outside a running period a new ratio applies directly; otherwise it
    // waits in the shadow for the next boundary.
    if (xfer) begin
      if (state_q == IDLE || state_d == IDLE) begin
        div_d = cfg_clamped;
      end else begin
        shadow_d     = cfg_clamped;
        shadow_vld_d = 1'b1;
      end
    end

    busy_d    = (state_d != IDLE);
    tick_d    = busy_d && (cnt_d == div_d - CNT_W'(1));
    clk_out_d = busy_d && (cnt_d < (div_d >> 1));
  end

  // State and output registers; reset discards any pending ratio and stop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      div_q        <= CNT_W'(DEF_DIV);
      shadow_q     <= '0;
      shadow_vld_q <= 1'b0;
      tick_q       <= 1'b0;
      clk_out_q    <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the values from before this edge.
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      div_q        <= div_d;
      shadow_q     <= shadow_d;
      shadow_vld_q <= shadow_vld_d;
      tick_q       <= tick_d;
      clk_out_q    <= clk_out_d;
    end
  end

  assign cfg_ready  = !shadow_vld_q;
  assign busy       = (state_q != IDLE);
  assign tick       = tick_q;
  assign clk_out    = clk_out_q;
  assign div_active = div_q;

endmodule

// File: tb/tb_freqdiv_ctrl.sv
// Testbench for freqdiv_ctrl: directed scenarios with literal expectations,
// plus a period-level behavioural model compared against the DUT every cycle.
module tb_freqdiv_ctrl;

  localparam int CNT_W   = 16;
  localparam int DEF_DIV = 50;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             cfg_valid = 1'b0;
  logic [CNT_W-1:0] cfg_div = '0;
  logic             cfg_ready;
  logic             start = 1'b0;
  logic             stop = 1'b0;
  logic             busy;
  logic             tick;
  logic             clk_out;
  logic [CNT_W-1:0] div_active;

  int n_cmp = 0;
  int n_bad = 0;

  freqdiv_ctrl #(.CNT_W(CNT_W), .DEF_DIV(DEF_DIV)) dut (
    .clk        (clk),
    .rst        (rst),
    .cfg_valid  (cfg_valid),
    .cfg_div    (cfg_div),
    .cfg_ready  (cfg_ready),
    .start      (start),
    .stop       (stop),
    .busy       (busy),
    .tick       (tick),
    .clk_out    (clk_out),
    .div_active (div_active)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: running flag, position within the period, ratio in
  // effect, pending ratio (-1 when none) and whether a stop is requested.
  bit m_busy = 0;
  bit m_stopping = 0;
  int m_pos = 0;
  int m_div = DEF_DIV;
  int m_pend = -1;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy = 0; m_stopping = 0; m_pos = 0; m_div = DEF_DIV; m_pend = -1;
    end else begin
      bit xfer;
      bit end_p;
      int req;
      xfer  = cfg_valid && (m_pend < 0);
      end_p = m_busy && (m_pos == m_div - 1);
      req   = (int'(cfg_div) < 2) ? 2 : int'(cfg_div);
      if (!m_busy) begin
        if (xfer) m_div = req;
        if (start && !stop) begin
          m_busy = 1; m_stopping = 0; m_pos = 0;
        end
      end else begin
        if (stop)       m_stopping = 1;
        else if (start) m_stopping = 0;
        if (end_p) begin
          if (m_pend >= 0) begin
            m_div = m_pend; m_pend = -1;
          end
          m_pos = 0;
          if (m_stopping) begin
            m_busy = 0;
            if (xfer) m_div = req;
          end else if (xfer) begin
            m_pend = req;
          end
        end else begin
          m_pos++;
          if (xfer) m_pend = req;
        end
      end
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    check("cmp_busy",      int'(busy),       int'(m_busy));
    check("cmp_tick",      int'(tick),       int'(m_busy && (m_pos == m_div - 1)));
    check("cmp_clk_out",   int'(clk_out),    int'(m_busy && (m_pos < m_div / 2)));
    check("cmp_cfg_ready", int'(cfg_ready),  int'(m_pend < 0));
    check("cmp_div",       int'(div_active), m_div);
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1; cyc(1); start = 1'b0;
  endtask

  task automatic write_idle(input int v);
    cfg_valid = 1'b1; cfg_div = CNT_W'(v); cyc(1); cfg_valid = 1'b0;
  endtask

  task automatic stop_and_wait_idle();
    stop = 1'b1; cyc(1); stop = 1'b0;
    for (int i = 0; i < 200 && busy; i++) cyc(1);
    check("idle_timeout", int'(busy), 0);
  endtask

  initial begin
    int first_tick;
    int highs;
    logic [9:0] pat;
    logic [9:0] tks;

    cyc(2);
    rst = 1'b0;
    cyc(1);
    check("rst_div",   int'(div_active), 50);
    check("rst_ready", int'(cfg_ready),  1);
    check("rst_busy",  int'(busy),       0);
    check("rst_clk",   int'(clk_out),    0);
    check("rst_tick",  int'(tick),       0);

    // Default ratio 50: first tick 50 cycles after start, 25 high cycles.
    pulse_start();
    check("def_busy_first", int'(busy),    1);
    check("def_clk_first",  int'(clk_out), 1);
    first_tick = 0; highs = 0;
    for (int k = 1; k <= 50; k++) begin
      if (tick && first_tick == 0) first_tick = k;
      highs += int'(clk_out);
      cyc(1);
    end
    check("def_first_tick", first_tick, 50);
    check("def_high_cnt",   highs,      25);
    stop_and_wait_idle();

    // Ratio 5 written in IDLE: pattern 1,1,0,0,0 with tick on the 5th cycle.
    write_idle(5);
    check("r5_div", int'(div_active), 5);
    pulse_start();
    pat = '0; tks = '0;
    for (int k = 0; k < 10; k++) begin
      pat = {pat[8:0], clk_out};
      tks = {tks[8:0], tick};
      cyc(1);
    end
    check("r5_clk_pat",  int'(pat), int'(10'b1100011000));
    check("r5_tick_pat", int'(tks), int'(10'b0000100001));
    stop_and_wait_idle();

    // Ratio 10 running, write 4 at cnt=3; a second offer is refused.
    write_idle(10);
    pulse_start();                 // cnt=0
    cyc(3);                        // cnt=3
    cfg_valid = 1'b1; cfg_div = 16'd4;
    cyc(1);                        // cnt=4
    check("r10_ready_low", int'(cfg_ready),  0);
    check("r10_div_held",  int'(div_active), 10);
    cfg_div = 16'd7;
    cyc(2);                        // cnt=6
    cfg_valid = 1'b0;
    cyc(3);                        // cnt=9
    check("r10_tick",      int'(tick),       1);
    check("r10_div_end",   int'(div_active), 10);
    cyc(1);                        // new period
    check("r4_div",        int'(div_active), 4);
    check("r4_ready",      int'(cfg_ready),  1);
    cyc(3);
    check("r4_tick",       int'(tick),       1);
    check("r4_div_kept",   int'(div_active), 4);
    stop_and_wait_idle();

    // Ratio 8: stop at cnt=2 completes the period.
    write_idle(8);
    pulse_start();                 // cnt=0
    cyc(2);                        // cnt=2
    stop = 1'b1; cyc(1); stop = 1'b0;   // cnt=3
    cyc(4);                        // cnt=7
    check("r8_stop_tick", int'(tick), 1);
    check("r8_stop_busy", int'(busy), 1);
    cyc(1);
    check("r8_idle_busy", int'(busy),    0);
    check("r8_idle_clk",  int'(clk_out), 0);

    // Same, but start at cnt=5 cancels the stop; phase continues.
    pulse_start();                 // cnt=0
    cyc(2);
    stop = 1'b1; cyc(1); stop = 1'b0;   // cnt=3
    cyc(2);                        // cnt=5
    pulse_start();                 // cnt=6
    cyc(1);                        // cnt=7
    check("r8_cancel_tick", int'(tick),    1);
    cyc(1);
    check("r8_cancel_busy", int'(busy),    1);
    check("r8_cancel_clk",  int'(clk_out), 1);
    cyc(7);
    check("r8_next_tick",   int'(tick),    1);
    stop_and_wait_idle();

    // Ratios 0 and 1 clamp to 2.
    write_idle(0);
    check("clamp0", int'(div_active), 2);
    write_idle(1);
    check("clamp1", int'(div_active), 2);
    pulse_start();
    pat = '0; tks = '0;
    for (int k = 0; k < 6; k++) begin
      pat = {pat[8:0], clk_out};
      tks = {tks[8:0], tick};
      cyc(1);
    end
    check("r2_clk_pat",  int'(pat), int'(10'b0000101010));
    check("r2_tick_pat", int'(tks), int'(10'b0000010101));

    // Reset mid-period with a pending shadow value.
    cfg_valid = 1'b1; cfg_div = 16'd9;
    cyc(1);
    cfg_valid = 1'b0;
    check("pend_ready", int'(cfg_ready), 0);
    @(posedge clk);
    #2 rst = 1'b1;
    cyc(1);
    check("mrst_busy",  int'(busy),       0);
    check("mrst_clk",   int'(clk_out),    0);
    check("mrst_tick",  int'(tick),       0);
    check("mrst_div",   int'(div_active), 50);
    check("mrst_ready", int'(cfg_ready),  1);
    rst = 1'b0;
    cyc(3);
    check("post_div",   int'(div_active), 50);
    check("post_ready", int'(cfg_ready),  1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
